cache_replace_ctrl: RTL and testbench
=====================================

Name: cache_replace_ctrl

Overview:
- Replacement controller for an 8-way set-associative cache.
- Holds per-set PLRU tree state (7 bits) and line-valid flags (8 bits) in flops.
- Serves victim-allocation requests through a valid/ready request and response handshake.
- Applies hit touches and invalidations, and sequences a full-array flush.

Parameters:
- NUM_SETS, 64, number of sets; power of two, at least 2. SET_W = log2(NUM_SETS) is derived.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous reset, active low
- alloc_req_valid_i  in  1  allocation request
- alloc_req_ready_o  out  1  request accepted when valid and ready are both high
- alloc_req_set_i  in  SET_W  set to allocate in
- alloc_resp_valid_o  out  1  victim response valid
- alloc_resp_ready_i  in  1  consumer takes the response
- alloc_resp_way_o  out  3  victim way
- alloc_resp_evict_o  out  1  victim line was valid (writeback/evict needed)
- touch_valid_i  in  1  hit access
- touch_set_i  in  SET_W  set of the hit
- touch_way_i  in  3  way of the hit
- inval_valid_i  in  1  invalidate one line
- inval_set_i  in  SET_W  set of the line to invalidate
- inval_way_i  in  3  way of the line to invalidate
- flush_req_i  in  1  flush request pulse
- flush_busy_o  out  1  flush in progress
- stat_alloc_cnt_o  out  32  see Optional Feature
- stat_evict_cnt_o  out  32  see Optional Feature

Behaviour:
- Reset: asynchronous, active low, on rst_n_i.
  - All plru and valid storage is cleared to 0; FSM enters IDLE; pending-flush flag is cleared.
  - Outputs: alloc_req_ready_o=1, alloc_resp_valid_o=0, way=0, evict=0, flush_busy_o=0, counters=0.
  - Reset asserted mid-operation aborts any transaction or flush immediately.
- PLRU tree layout:
  - node6 is the root and chooses between ways 0-3 and 4-7.
  - node5 covers 4-7 and node4 covers 0-3.
  - Leaves: node3 covers ways 6/7, node2 ways 4/5, node1 ways 2/3, node0 ways 0/1.
  - A node bit of 1 selects the upper half.
- Touch of way w (sets nodes to point away from w):
  - node6 = ~w[2].
  - If w[2]=1: node5 = ~w[1], then node3 (if w[1]=1) or node2 (if w[1]=0) = ~w[0].
  - If w[2]=0: node4 = ~w[1], then node1 (if w[1]=1) or node0 (if w[1]=0) = ~w[0].
  - All other node bits are unchanged.
- Victim selection, evaluated at every node:
  - If exactly one subtree is fully valid, take the other subtree.
  - Otherwise follow the node's plru bit.
  - evict = valid[victim].
- FSM: IDLE -> LOOKUP -> RESP -> IDLE, plus FLUSH.
  - IDLE: ready=1 unless a flush is pending. On accept at cycle T, latch the set and go to LOOKUP.
  - LOOKUP (T+1): compute victim from current storage plus same-cycle writes; register way and evict; go to RESP.
  - RESP (from T+2): resp_valid=1; way and evict stay stable until resp_ready_i.
  - On response handshake: set valid[way]=1 and touch that way in the latched set; return to IDLE. Next accept is possible at handshake+1.
- Touch and inval are accepted in IDLE, LOOKUP and RESP, one cycle write.
  - Neither changes a response already latched, including inval of the pending way.
- Same-cycle collisions on the same set:
  - Alloc commit plru update overrides the touch update.
  - Commit valid set overrides inval of the same way.
  - Touch and inval on the same line: both apply.
- Flush:
  - flush_req_i sets a pending flag in any non-FLUSH state.
  - The flag is taken in IDLE before any new allocation.
  - FLUSH clears plru and valid of one set per cycle for sets 0..NUM_SETS-1, taking NUM_SETS cycles.
  - flush_busy_o=1 throughout FLUSH; then return to IDLE.
  - Touch, inval and flush_req_i are ignored while in FLUSH.

Optional Feature:
- Macro: CACHE_REPLACE_STAT_EN.
- Defined:
  - stat_alloc_cnt_o increments on each response handshake.
  - stat_evict_cnt_o increments on each handshake with evict=1.
  - Both counters saturate at 0xFFFFFFFF.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- After reset, alloc set 5 with resp_ready held high.
  - resp_valid rises 2 cycles after accept; way=0, evict=0.
  - Eight consecutive allocs to set 5 return ways 0,4,2,6,1,5,3,7, all with evict=0.
  - A ninth alloc returns way=0, evict=1.
- Fill set 5 fully, inval set 5 way 5, then alloc set 5 -> way=5, evict=0.
- Alloc in RESP with resp_ready low for 5 cycles while touching set 5 way 4 and invalidating its pending way.
  - way and evict are unchanged until handshake; ready=0 throughout.
- Flush pulsed during RESP.
  - After handshake: flush_busy_o=1 for exactly 64 cycles; alloc_req_ready_o=0 during flush.
  - Then alloc to any set returns way=0, evict=0.
- Assert rst_n_i mid-flush and mid-RESP.
  - Outputs return to reset values asynchronously; the next alloc returns way=0.
- With CACHE_REPLACE_STAT_EN defined, run 9 allocs to one set -> alloc count=9, evict count=1.
  - Without the macro, both counters read 0.

Source files
------------

// File: rtl/cache_replace_ctrl.sv
// cache_replace_ctrl
//   Replacement controller for an 8-way set-associative cache. Each set keeps a
//   7-bit tree-PLRU state and 8 line-valid flags in flops. Victim allocation
//   runs through a request/response valid-ready pair. Hit touches and single
//   line invalidations are one-cycle writes. A flush clears the whole array,
//   one set per cycle.
//
//   Optional statistics counters: define CACHE_REPLACE_STAT_EN to build them.
//   When it is undefined the counter outputs are tied to zero.
//
// Ports
//   clk_i               clock
//   rst_n_i             asynchronous reset, active low
//   alloc_req_valid_i   allocation request
//   alloc_req_ready_o   request accepted when valid and ready are both high
//   alloc_req_set_i     set to allocate in
//   alloc_resp_valid_o  victim response valid
//   alloc_resp_ready_i  consumer takes the response
//   alloc_resp_way_o    victim way
//   alloc_resp_evict_o  victim line was valid (writeback/evict needed)
//   touch_valid_i       hit access
//   touch_set_i         set of the hit
//   touch_way_i         way of the hit
//   inval_valid_i       invalidate one line
//   inval_set_i         set of the line to invalidate
//   inval_way_i         way of the line to invalidate
//   flush_req_i         flush request pulse
//   flush_busy_o        flush in progress
//   stat_alloc_cnt_o    number of response handshakes (saturating)
//   stat_evict_cnt_o    number of handshakes that reported evict (saturating)
//
// FSM states
//   state  | meaning
//   IDLE   | ready for a request; a pending flush is taken before any new one
//   LOOKUP | victim chosen for the latched set and registered
//   RESP   | response presented; held until alloc_resp_ready_i
//   FLUSH  | clearing one set per cycle, sets 0..NUM_SETS-1

module cache_replace_ctrl #(
  parameter int NUM_SETS = 64,
  localparam int SET_W = $clog2(NUM_SETS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             alloc_req_valid_i,
  output logic             alloc_req_ready_o,
  input  logic [SET_W-1:0] alloc_req_set_i,
  output logic             alloc_resp_valid_o,
  input  logic             alloc_resp_ready_i,
  output logic [2:0]       alloc_resp_way_o,
  output logic             alloc_resp_evict_o,
  input  logic             touch_valid_i,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [2:0]       touch_way_i,
  input  logic             inval_valid_i,
  input  logic [SET_W-1:0] inval_set_i,
  input  logic [2:0]       inval_way_i,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic [31:0]      stat_alloc_cnt_o,
  output logic [31:0]      stat_evict_cnt_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  localparam logic [SET_W-1:0] FLUSH_LOAD = SET_W'(NUM_SETS - 1);

  // Tree layout: node6 root (0-3 vs 4-7), node5 ways 4-7, node4 ways 0-3,
  // node3 6/7, node2 4/5, node1 2/3, node0 0/1. A 1 selects the upper half.
  function automatic logic [6:0] plru_touch(input logic [6:0] plru,
                                            input logic [2:0] way);
    logic [6:0] nxt;
    nxt    = plru;
    nxt[6] = ~way[2];
    if (way[2]) begin
      nxt[5] = ~way[1];
      if (way[1]) nxt[3] = ~way[0];
      else        nxt[2] = ~way[0];
    end else begin
      nxt[4] = ~way[1];
      if (way[1]) nxt[1] = ~way[0];
      else        nxt[0] = ~way[0];
    end
    return nxt;
  endfunction

  // A fully valid subtree is avoided when its sibling still has a free line;
  // otherwise the PLRU bit decides.
  function automatic logic pick_upper(input logic lo_full,
                                      input logic hi_full,
                                      input logic plru_bit);
    logic upper;
    if (lo_full && !hi_full)      upper = 1'b1;
    else if (hi_full && !lo_full) upper = 1'b0;
    else                          upper = plru_bit;
    return upper;
  endfunction

  function automatic logic [2:0] plru_victim(input logic [6:0] plru,
                                             input logic [7:0] valid);
    logic [2:0] way;
    way[2] = pick_upper(&valid[3:0], &valid[7:4], plru[6]);
    if (way[2]) begin
      way[1] = pick_upper(&valid[5:4], &valid[7:6], plru[5]);
      if (way[1]) way[0] = pick_upper(valid[6], valid[7], plru[3]);
      else        way[0] = pick_upper(valid[4], valid[5], plru[2]);
    end else begin
      way[1] = pick_upper(&valid[1:0], &valid[3:2], plru[4]);
      if (way[1]) way[0] = pick_upper(valid[2], valid[3], plru[1]);
      else        way[0] = pick_upper(valid[0], valid[1], plru[0]);
    end
    return way;
  endfunction

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             flush_pend_q;
  logic [SET_W-1:0] flush_cnt_q;
  logic [SET_W-1:0] flush_set;
  logic [SET_W-1:0] lat_set_q;
  logic [2:0]       resp_way_q;
  logic             resp_evict_q;

  logic [6:0]       plru_q  [NUM_SETS];
  logic [7:0]       valid_q [NUM_SETS];

  logic             req_accept;
  logic             resp_commit;
  logic [6:0]       byp_plru;
  logic [7:0]       byp_valid;
  logic [2:0]       victim_way;
  logic             victim_evict;

  assign alloc_req_ready_o  = (state_q == IDLE) && !flush_pend_q;
  assign req_accept         = alloc_req_valid_i && alloc_req_ready_o;
  assign resp_commit        = (state_q == RESP) && alloc_resp_ready_i;
  assign alloc_resp_valid_o = (state_q == RESP);
  assign alloc_resp_way_o   = resp_way_q;
  assign alloc_resp_evict_o = resp_evict_q;
  assign flush_busy_o       = (state_q == FLUSH);

  // The flush timer counts down from NUM_SETS-1; with NUM_SETS a power of two
  // its complement walks the set index upward from 0.
  assign flush_set = ~flush_cnt_q;

  // Victim for the latched set sees touches and invalidations landing in the
  // same LOOKUP cycle, so the choice matches what storage will hold next.
  always_comb begin
    byp_plru  = plru_q[lat_set_q];
    byp_valid = valid_q[lat_set_q];
    if (touch_valid_i && (touch_set_i == lat_set_q)) begin
      byp_plru = plru_touch(byp_plru, touch_way_i);
    end
    if (inval_valid_i && (inval_set_i == lat_set_q)) begin
      byp_valid[inval_way_i] = 1'b0;
    end
    victim_way   = plru_victim(byp_plru, byp_valid);
    victim_evict = byp_valid[victim_way];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_pend_q)           state_d = FLUSH;
        else if (alloc_req_valid_i) state_d = LOOKUP;
      end
      LOOKUP: state_d = RESP;
      RESP: begin
        if (alloc_resp_ready_i) state_d = IDLE;
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      lat_set_q    <= '0;
      resp_way_q   <= '0;
      resp_evict_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // A pending flush is consumed on the IDLE->FLUSH transition; requests
      // arriving during FLUSH are dropped.
      if ((state_q == IDLE) && flush_pend_q) begin
        flush_pend_q <= 1'b0;
        flush_cnt_q  <= FLUSH_LOAD;
      end else if (state_q == FLUSH) begin
        flush_pend_q <= 1'b0;
        if (flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - 1'b1;
      end else if (flush_req_i) begin
        flush_pend_q <= 1'b1;
      end

      if (req_accept) lat_set_q <= alloc_req_set_i;

      if (state_q == LOOKUP) begin
        resp_way_q   <= victim_way;
        resp_evict_q <= victim_evict;
      end
    end
  end

  // Storage writes. Later non-blocking writes win, so the commit overrides a
  // same-cycle invalidate of the allocated way. A touch to the set being
  // committed is dropped so the commit defines that set's tree state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else if (state_q == FLUSH) begin
      plru_q[flush_set]  <= '0;
      valid_q[flush_set] <= '0;
    end else begin
      if (touch_valid_i && !(resp_commit && (touch_set_i == lat_set_q))) begin
        plru_q[touch_set_i] <= plru_touch(plru_q[touch_set_i], touch_way_i);
      end
      if (inval_valid_i) begin
        valid_q[inval_set_i][inval_way_i] <= 1'b0;
      end
      if (resp_commit) begin
        plru_q[lat_set_q]              <= plru_touch(plru_q[lat_set_q], resp_way_q);
        valid_q[lat_set_q][resp_way_q] <= 1'b1;
      end
    end
  end

`ifdef CACHE_REPLACE_STAT_EN
  logic [31:0] stat_alloc_q;
  logic [31:0] stat_evict_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_alloc_q <= '0;
      stat_evict_q <= '0;
    end else if (resp_commit) begin
      if (stat_alloc_q != 32'hFFFF_FFFF) stat_alloc_q <= stat_alloc_q + 32'd1;
      if (resp_evict_q && (stat_evict_q != 32'hFFFF_FFFF)) begin
        stat_evict_q <= stat_evict_q + 32'd1;
      end
    end
  end

  assign stat_alloc_cnt_o = stat_alloc_q;
  assign stat_evict_cnt_o = stat_evict_q;
`else
  assign stat_alloc_cnt_o = '0;
  assign stat_evict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Directed bench for cache_replace_ctrl (NUM_SETS=64). Expected victims are
// hand-derived from the tree-PLRU rules.

module tb_cache_replace_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        alloc_req_valid_i;
  logic        alloc_req_ready_o;
  logic [5:0]  alloc_req_set_i;
  logic        alloc_resp_valid_o;
  logic        alloc_resp_ready_i;
  logic [2:0]  alloc_resp_way_o;
  logic        alloc_resp_evict_o;
  logic        touch_valid_i;
  logic [5:0]  touch_set_i;
  logic [2:0]  touch_way_i;
  logic        inval_valid_i;
  logic [5:0]  inval_set_i;
  logic [2:0]  inval_way_i;
  logic        flush_req_i;
  logic        flush_busy_o;
  logic [31:0] stat_alloc_cnt_o;
  logic [31:0] stat_evict_cnt_o;

  int errors = 0;
  int checks = 0;

  cache_replace_ctrl #(.NUM_SETS(64)) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .alloc_req_valid_i  (alloc_req_valid_i),
    .alloc_req_ready_o  (alloc_req_ready_o),
    .alloc_req_set_i    (alloc_req_set_i),
    .alloc_resp_valid_o (alloc_resp_valid_o),
    .alloc_resp_ready_i (alloc_resp_ready_i),
    .alloc_resp_way_o   (alloc_resp_way_o),
    .alloc_resp_evict_o (alloc_resp_evict_o),
    .touch_valid_i      (touch_valid_i),
    .touch_set_i        (touch_set_i),
    .touch_way_i        (touch_way_i),
    .inval_valid_i      (inval_valid_i),
    .inval_set_i        (inval_set_i),
    .inval_way_i        (inval_way_i),
    .flush_req_i        (flush_req_i),
    .flush_busy_o       (flush_busy_o),
    .stat_alloc_cnt_o   (stat_alloc_cnt_o),
    .stat_evict_cnt_o   (stat_evict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  alloc_req_ready_o, 1);
    check({tag, "_rvalid"}, alloc_resp_valid_o, 0);
    check({tag, "_way"},    alloc_resp_way_o, 0);
    check({tag, "_evict"},  alloc_resp_evict_o, 0);
    check({tag, "_busy"},   flush_busy_o, 0);
    check({tag, "_acnt"},   stat_alloc_cnt_o, 0);
    check({tag, "_ecnt"},   stat_evict_cnt_o, 0);
  endtask

  task automatic check_stats(input string tag, input int exp_alloc, input int exp_evict);
`ifdef CACHE_REPLACE_STAT_EN
    check({tag, "_acnt"}, stat_alloc_cnt_o, exp_alloc);
    check({tag, "_ecnt"}, stat_evict_cnt_o, exp_evict);
`else
    check({tag, "_acnt"}, stat_alloc_cnt_o, 0);
    check({tag, "_ecnt"}, stat_evict_cnt_o, 0);
`endif
  endtask

  // Called at posedge+1 with alloc_resp_ready_i high; returns at posedge+1
  // one cycle after the handshake.
  task automatic do_alloc(input int set, input int exp_way, input int exp_evict,
                          input string tag);
    check({tag, "_ready"}, alloc_req_ready_o, 1);
    alloc_req_valid_i = 1'b1;
    alloc_req_set_i   = 6'(set);
    @(posedge clk_i); #1;
    alloc_req_valid_i = 1'b0;
    check({tag, "_lookup_rvalid"}, alloc_resp_valid_o, 0);
    @(posedge clk_i); #1;
    check({tag, "_rvalid"}, alloc_resp_valid_o, 1);
    check({tag, "_way"},    alloc_resp_way_o, exp_way);
    check({tag, "_evict"},  alloc_resp_evict_o, exp_evict);
    @(posedge clk_i); #1;
    check({tag, "_done_rvalid"}, alloc_resp_valid_o, 0);
  endtask

  initial begin
    int exp_seq [8];
    int busy_cycles;
    int rdy_during_flush;

    exp_seq = '{0, 4, 2, 6, 1, 5, 3, 7};

    rst_n_i            = 1'b0;
    alloc_req_valid_i  = 1'b0;
    alloc_req_set_i    = '0;
    alloc_resp_ready_i = 1'b1;
    touch_valid_i      = 1'b0;
    touch_set_i        = '0;
    touch_way_i        = '0;
    inval_valid_i      = 1'b0;
    inval_set_i        = '0;
    inval_way_i        = '0;
    flush_req_i        = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Eight allocations into empty set 5, then a ninth that must evict.
    for (int i = 0; i < 8; i++) begin
      do_alloc(5, exp_seq[i], 0, $sformatf("fill%0d", i));
    end
    do_alloc(5, 0, 1, "ninth");
    check_stats("stats9", 9, 1);

    // Free way 5 in the full set; it must be chosen without eviction.
    inval_valid_i = 1'b1;
    inval_set_i   = 6'd5;
    inval_way_i   = 3'd5;
    @(posedge clk_i); #1;
    inval_valid_i = 1'b0;
    do_alloc(5, 5, 0, "after_inval");

    // Response held for 5 cycles while touching way 4 and invalidating the
    // pending way 2; a flush request arrives on the last held cycle.
    alloc_resp_ready_i = 1'b0;
    check("hold_ready", alloc_req_ready_o, 1);
    alloc_req_valid_i = 1'b1;
    alloc_req_set_i   = 6'd5;
    @(posedge clk_i); #1;
    alloc_req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("hold_rvalid", alloc_resp_valid_o, 1);
    check("hold_way",    alloc_resp_way_o, 2);
    check("hold_evict",  alloc_resp_evict_o, 1);
    for (int i = 0; i < 5; i++) begin
      touch_valid_i = 1'b1;
      touch_set_i   = 6'd5;
      touch_way_i   = 3'd4;
      inval_valid_i = 1'b1;
      inval_set_i   = 6'd5;
      inval_way_i   = 3'd2;
      flush_req_i   = (i == 4);
      @(posedge clk_i); #1;
      check($sformatf("hold%0d_rvalid", i), alloc_resp_valid_o, 1);
      check($sformatf("hold%0d_way", i),    alloc_resp_way_o, 2);
      check($sformatf("hold%0d_evict", i),  alloc_resp_evict_o, 1);
      check($sformatf("hold%0d_ready", i),  alloc_req_ready_o, 0);
    end
    touch_valid_i      = 1'b0;
    inval_valid_i      = 1'b0;
    flush_req_i        = 1'b0;
    alloc_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_hs_rvalid", alloc_resp_valid_o, 0);
    check("post_hs_ready",  alloc_req_ready_o, 0);
    check("post_hs_busy",   flush_busy_o, 0);

    busy_cycles      = 0;
    rdy_during_flush = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i); #1;
      if (!flush_busy_o) break;
      busy_cycles++;
      if (alloc_req_ready_o) rdy_during_flush++;
    end
    check("flush_cycles",     busy_cycles, 64);
    check("flush_ready_seen", rdy_during_flush, 0);
    check("flush_end_ready",  alloc_req_ready_o, 1);
    check_stats("stats_flush", 11, 2);

    do_alloc(5,  0, 0, "postflush_s5");
    do_alloc(17, 0, 0, "postflush_s17");
    do_alloc(40, 0, 0, "pre_rst_s40");
    check_stats("stats14", 14, 2);

    // Reset in the middle of a flush, before set 40 is reached.
    flush_req_i = 1'b1;
    @(posedge clk_i); #1;
    flush_req_i = 1'b0;
    @(posedge clk_i); #1;
    check("midflush_busy", flush_busy_o, 1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_flush");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    do_alloc(40, 0, 0, "after_rst_flush");

    // Reset while a response is presented.
    alloc_resp_ready_i = 1'b0;
    alloc_req_valid_i  = 1'b1;
    alloc_req_set_i    = 6'd40;
    @(posedge clk_i); #1;
    alloc_req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("resp_pre_rst_rvalid", alloc_resp_valid_o, 1);
    check("resp_pre_rst_way",    alloc_resp_way_o, 4);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    @(negedge clk_i);
    rst_n_i            = 1'b1;
    alloc_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    do_alloc(40, 0, 0, "after_rst_resp");
    check_stats("stats_end", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
